// File: rtl/echo_pkg.sv
// echo_pkg: FSM state type and default parameters for the ultrasonic echo receiver.
package echo_pkg;
    typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, MEASURE, DONE} state_t;
    localparam int DEF_CYC_PER_CM = 2900;
    localparam int DEF_TIMEOUT    = 1900000;
    localparam int DEF_CRASH_CM   = 20;
    localparam int DEF_CONFIRM    = 3;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a single asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] ff_q, ff_d;
    assign ff_d = {ff_q[0], d};
    assign q = ff_q[1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff_q <= '0;
        else ff_q <= ff_d;
    end
endmodule

// File: rtl/echo_receive.sv
// echo_receive: times a sensor echo pulse into centimetres and flags near objects.
// Define ECHO_FILTER_EN to require CONFIRM consecutive close results before crash rises.
module echo_receive
    import echo_pkg::*;
#(
    parameter int CYC_PER_CM = DEF_CYC_PER_CM,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CRASH_CM   = DEF_CRASH_CM,
    parameter int CONFIRM    = DEF_CONFIRM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic        echo,
    output logic [15:0] dist_cm,
    output logic        valid,
    output logic        timeout_err,
    output logic        crash
);
    localparam int SW = CYC_PER_CM > 1 ? $clog2(CYC_PER_CM) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    logic echo_s, rise, fall, tmo_hit, wrap, close;
    state_t state_q, state_d;
    logic echo_prev_q;
    logic [SW-1:0] sub_q, sub_d;
    logic [15:0] cm_q, cm_d, dist_q, dist_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic valid_q, valid_d, terr_q, terr_d, crash_q, crash_d;
`ifdef ECHO_FILTER_EN
    localparam int RW = $clog2(CONFIRM + 1);
    logic [RW-1:0] run_q, run_d;
`endif

    sync2 u_sync (.clk(clk), .rst(rst), .d(echo), .q(echo_s));

    assign rise    = echo_s & ~echo_prev_q;
    assign fall    = ~echo_s & echo_prev_q;
    assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
    assign wrap    = sub_q == SW'(CYC_PER_CM - 1);
    assign close   = cm_q < 16'(CRASH_CM);

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        tmo_d   = tmo_q;
        dist_d  = dist_q;
        valid_d = 1'b0;
        terr_d  = 1'b0;
        crash_d = crash_q;
`ifdef ECHO_FILTER_EN
        run_d   = run_q;
`endif
        case (state_q)
            IDLE: state_d = trig ? ARM : IDLE;
            ARM: begin
                tmo_d   = '0;
                state_d = trig ? ARM : WAIT_RISE;
            end
            WAIT_RISE: begin
                if (trig) begin
                    state_d = ARM;
                end else if (rise) begin
                    state_d = MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            MEASURE: begin
                if (trig) begin
                    state_d = ARM;
                end else begin
                    // the falling-edge cycle still counts, so N synced high cycles give N ticks
                    sub_d = wrap ? '0 : sub_q + 1'b1;
                    cm_d  = (wrap && cm_q != 16'hFFFF) ? cm_q + 16'd1 : cm_q;
                    if (fall) begin
                        state_d = DONE;
                    end else if (tmo_hit) begin
                        state_d = IDLE;
                        terr_d  = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (trig) begin
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    dist_d  = cm_q;
`ifdef ECHO_FILTER_EN
                    run_d   = !close ? '0 : (run_q == RW'(CONFIRM) ? run_q : run_q + 1'b1);
                    crash_d = run_d == RW'(CONFIRM);
`else
                    crash_d = close;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            echo_prev_q <= 1'b0;
            sub_q       <= '0;
            cm_q        <= '0;
            tmo_q       <= '0;
            dist_q      <= '0;
            valid_q     <= 1'b0;
            terr_q      <= 1'b0;
            crash_q     <= 1'b0;
`ifdef ECHO_FILTER_EN
            run_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            echo_prev_q <= echo_s;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            tmo_q       <= tmo_d;
            dist_q      <= dist_d;
            valid_q     <= valid_d;
            terr_q      <= terr_d;
            crash_q     <= crash_d;
`ifdef ECHO_FILTER_EN
            run_q       <= run_d;
`endif
        end
    end

    assign dist_cm     = dist_q;
    assign valid       = valid_q;
    assign timeout_err = terr_q;
    assign crash       = crash_q;
endmodule

// File: tb/tb_echo_receive.sv
// tb_echo_receive: directed checks of echo timing, timeout, crash flag, reset and abort.
module tb_echo_receive;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trig = 1'b0;
    logic        echo = 1'b0;
    logic [15:0] dist_cm;
    logic        valid, timeout_err, crash;
    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int tcnt = 0;
    int both = 0;
    int v0, t0, n;

    echo_receive #(.CYC_PER_CM(4), .TIMEOUT(200), .CRASH_CM(10), .CONFIRM(3)) dut (
        .clk(clk), .rst(rst), .trig(trig), .echo(echo),
        .dist_cm(dist_cm), .valid(valid), .timeout_err(timeout_err), .crash(crash)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) vcnt++;
        if (timeout_err) tcnt++;
        if (valid && timeout_err) both++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic measure(input int tl, input int el);
        trig = 1'b1;
        cyc(tl);
        trig = 1'b0;
        cyc(3);
        echo = 1'b1;
        cyc(el);
        echo = 1'b0;
        cyc(8);
    endtask

    initial begin
        cyc(3);
        chk("rst_dist", dist_cm, 0);
        chk("rst_valid", valid, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_crash", crash, 0);
        rst = 1'b1;
        cyc(2);

        measure(5, 40);
        chk("m40_vcnt", vcnt, 1);
        chk("m40_dist", dist_cm, 10);
        chk("m40_crash", crash, 0);
        chk("m40_tcnt", tcnt, 0);

        trig = 1'b1;
        cyc(3);
        trig = 1'b0;
        n = 0;
        while (n < 300 && !timeout_err) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_seen", int'(n >= 199 && n <= 202), 1);
        cyc(3);
        chk("tmo_tcnt", tcnt, 1);
        chk("tmo_vcnt", vcnt, 1);
        chk("tmo_dist", dist_cm, 10);

`ifdef ECHO_FILTER_EN
        measure(5, 32);
        chk("f1_crash", crash, 0);
        measure(5, 32);
        chk("f2_crash", crash, 0);
        measure(5, 32);
        chk("f3_dist", dist_cm, 8);
        chk("f3_crash", crash, 1);
        measure(5, 48);
        chk("f4_dist", dist_cm, 12);
        chk("f4_crash", crash, 0);
        chk("f_vcnt", vcnt, 5);
`else
        measure(5, 32);
        chk("n8_dist", dist_cm, 8);
        chk("n8_crash", crash, 1);
        measure(5, 160);
        chk("n40_dist", dist_cm, 40);
        chk("n40_crash", crash, 0);
        chk("n_vcnt", vcnt, 3);
`endif

        v0 = vcnt;
        trig = 1'b1;
        cyc(5);
        trig = 1'b0;
        cyc(3);
        echo = 1'b1;
        cyc(10);
        rst = 1'b0;
        #1;
        chk("mrst_dist", dist_cm, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_terr", timeout_err, 0);
        chk("mrst_crash", crash, 0);
        cyc(2);
        rst = 1'b1;
        cyc(10);
        echo = 1'b0;
        cyc(10);
        chk("mrst_novalid", vcnt, v0);

        v0 = vcnt;
        t0 = tcnt;
        trig = 1'b1;
        cyc(5);
        trig = 1'b0;
        cyc(3);
        echo = 1'b1;
        cyc(10);
        trig = 1'b1;
        cyc(2);
        trig = 1'b0;
        cyc(5);
        echo = 1'b0;
        cyc(4);
        chk("abort_novalid", vcnt, v0);
        echo = 1'b1;
        cyc(20);
        echo = 1'b0;
        cyc(8);
        chk("abort_vcnt", vcnt, v0 + 1);
        chk("abort_dist", dist_cm, 5);
        chk("abort_tcnt", tcnt, t0);

        v0 = vcnt;
        measure(5, 1);
        chk("zero_vcnt", vcnt, v0 + 1);
        chk("zero_dist", dist_cm, 0);
        chk("both_never", both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
